calc_shift_ctrl: RTL and testbench

Command sequencer for the calculator's 5-bit load/shift result register. It accepts one operation per handshake (load, shift right, shift left, or load-then-shift-left) and issues the per-cycle `op_reg` command stream that the register consumes. It keeps a shadow copy of the register contents and a lost-bit flag, and pulses `done` when the sequence completes. It sits between the calculator's top-level control FSM and the result register.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_shadow_reg.sv | 42 ++++
 rtl/calc_shift_ctrl.sv | 113 +++++++++++
 tb/tb_calc_shift_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator's shift/load result register and its sequencer.
// Holds the op_reg/cmd codes and the sequencer state type.
package calc_pkg;

   // op_reg command codes consumed by the result register
   localparam logic [1:0] OPR_HOLD = 2'b00;
   localparam logic [1:0] OPR_LOAD = 2'b01;
   localparam logic [1:0] OPR_SHR  = 2'b10;
   localparam logic [1:0] OPR_SHL  = 2'b11;

   localparam logic [1:0] CMD_LOAD     = 2'b00;
   localparam logic [1:0] CMD_SHR      = 2'b01;
   localparam logic [1:0] CMD_SHL      = 2'b10;
   localparam logic [1:0] CMD_LOAD_SHL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   function automatic logic is_load_cmd(input logic [1:0] c);
      return (c == CMD_LOAD) || (c == CMD_LOAD_SHL);
   endfunction

endpackage

// File: rtl/calc_shadow_reg.sv
// Load/shift register driven by an op_reg command; mirrors the calculator result register.
// shift_out is the bit leaving the register when the current command is a shift.
module calc_shadow_reg
   import calc_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             shift_out
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         case (op)
            OPR_LOAD: r_q <= d;
            OPR_SHR:  r_q <= {1'b0, r_q[WIDTH-1:1]};
            OPR_SHL:  r_q <= {r_q[WIDTH-2:0], 1'b0};
            default:  r_q <= r_q;
         endcase
      end
   end

   always_comb begin
      shift_out = 1'b0;
      case (op)
         OPR_SHR: shift_out = r_q[0];
         OPR_SHL: shift_out = r_q[WIDTH-1];
         default: shift_out = 1'b0;
      endcase
   end

   assign q = r_q;

endmodule

// File: rtl/calc_shift_ctrl.sv
// Command sequencer for the 5-bit load/shift result register: turns one accepted
// operation into a per-cycle op_reg stream, tracks a shadow copy and a lost-bit flag.
module calc_shift_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cmd,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       op_reg,
   output logic [WIDTH-1:0] reg_in,
   output logic             busy,
   output logic             done,
   output logic             lost,
   output logic [WIDTH-1:0] shadow,
   output state_t           dbg_state
);

   // Handshake: start is a request taken only when the sequencer is idle (busy=0);
   // it is dropped, not queued, while busy=1 (including the done cycle).
   state_t           r_state;
   state_t           w_next_state;
   logic [1:0]       r_cmd;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_din;
   logic             r_busy;
   logic             r_done;
   logic             r_lost;
   logic [1:0]       w_op_reg;
   logic             w_accept;
   logic             w_shift_out;
   logic [WIDTH-1:0] w_shadow;

   assign w_accept = (r_state == ST_IDLE) && start;

   always_comb begin
      w_next_state = r_state;
      w_op_reg     = OPR_HOLD;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (is_load_cmd(cmd))       w_next_state = ST_LOAD;
               else if (amount != '0)      w_next_state = ST_SHIFT;
               else                        w_next_state = ST_DONE;
            end
         end
         ST_LOAD: begin
            w_op_reg = OPR_LOAD;
            if ((r_cmd == CMD_LOAD_SHL) && (r_cnt != '0)) w_next_state = ST_SHIFT;
            else                                          w_next_state = ST_DONE;
         end
         ST_SHIFT: begin
            w_op_reg = (r_cmd == CMD_SHR) ? OPR_SHR : OPR_SHL;
            if (r_cnt == CNT_W'(1)) w_next_state = ST_DONE;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cmd   <= CMD_LOAD;
         r_cnt   <= '0;
         r_din   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_lost  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (w_next_state == ST_DONE);
         if (w_accept) begin
            r_cmd  <= cmd;
            r_cnt  <= amount;
            r_din  <= din;
            r_lost <= 1'b0;
         end else if (r_state == ST_SHIFT) begin
            r_cnt  <= r_cnt - 1'b1;
            r_lost <= r_lost | w_shift_out;
         end
      end
   end

   calc_shadow_reg #(
      .WIDTH (WIDTH)
   ) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .op        (w_op_reg),
      .d         (r_din),
      .q         (w_shadow),
      .shift_out (w_shift_out)
   );

   assign op_reg    = w_op_reg;
   assign reg_in    = r_din;
   assign busy      = r_busy;
   assign done      = r_done;
   assign lost      = r_lost;
   assign shadow    = w_shadow;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_shift_ctrl.sv
// Bench for calc_shift_ctrl: directed test-plan steps plus random commands checked
// against an arithmetic model of the shadow register and the expected op_reg stream.
module tb_calc_shift_ctrl;
   import calc_pkg::*;

   localparam int WIDTH = 5;
   localparam int CNT_W = 3;

   logic             clk;
   logic             rst;
   logic             start;
   logic [1:0]       cmd;
   logic [CNT_W-1:0] amount;
   logic [WIDTH-1:0] din;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] reg_in;
   logic             busy;
   logic             done;
   logic             lost;
   logic [WIDTH-1:0] shadow;
   state_t           dbg_state;

   int n_checks;
   int n_fail;
   int m_shadow;
   int m_lost;
   logic [1:0] exp_q[$];

   calc_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cmd       (cmd),
      .amount    (amount),
      .din       (din),
      .op_reg    (op_reg),
      .reg_in    (reg_in),
      .busy      (busy),
      .done      (done),
      .lost      (lost),
      .shadow    (shadow),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one command and check every cycle through the return to idle.
   // poke: hold start high with junk cmd/din while busy; it must be ignored.
   task automatic run_cmd(input logic [1:0] c, input int n, input int d, input bit poke);
      int v;
      int t;
      int exp_lost;
      @(negedge clk);
      start  = 1'b1;
      cmd    = c;
      amount = CNT_W'(n);
      din    = WIDTH'(d);
      tick();
      start = poke;
      if (poke) begin
         cmd    = CMD_LOAD;
         amount = '0;
         din    = WIDTH'(~d);
      end
      // reference model
      exp_q.delete();
      v = (c == CMD_LOAD || c == CMD_LOAD_SHL) ? d : m_shadow;
      exp_lost = 0;
      if (c == CMD_LOAD || c == CMD_LOAD_SHL) exp_q.push_back(OPR_LOAD);
      if (c == CMD_SHR) begin
         exp_lost = ((v & ((1 << n) - 1)) != 0) ? 1 : 0;
         v = v >> n;
         for (int i = 0; i < n; i++) exp_q.push_back(OPR_SHR);
      end else if (c == CMD_SHL || c == CMD_LOAD_SHL) begin
         t = v << n;
         exp_lost = ((t >> WIDTH) != 0) ? 1 : 0;
         v = t & ((1 << WIDTH) - 1);
         for (int i = 0; i < n; i++) exp_q.push_back(OPR_SHL);
      end
      while (exp_q.size() > 0) begin
         check("op_reg_seq", op_reg, exp_q.pop_front());
         check("busy_seq", busy, 1);
         check("done_seq", done, 0);
         check("reg_in_seq", reg_in, d);
         tick();
      end
      check("done_pulse", done, 1);
      check("busy_done", busy, 1);
      check("op_reg_done", op_reg, OPR_HOLD);
      check("reg_in_done", reg_in, d);
      tick();
      start = 1'b0;
      m_shadow = v;
      m_lost   = exp_lost;
      check("busy_idle", busy, 0);
      check("done_idle", done, 0);
      check("op_reg_idle", op_reg, OPR_HOLD);
      check("shadow", shadow, m_shadow);
      check("lost", lost, m_lost);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_shadow = 0;
      m_lost   = 0;
      rst    = 1'b1;
      start  = 1'b0;
      cmd    = CMD_LOAD;
      amount = '0;
      din    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_op_reg", op_reg, 0);
      check("rst_reg_in", reg_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_lost", lost, 0);
      check("rst_shadow", shadow, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // test-plan sequence
      run_cmd(CMD_LOAD, 0, 5'b10110, 0);
      check("plan_load_shadow", shadow, 5'b10110);
      run_cmd(CMD_SHR, 2, 0, 0);
      check("plan_shr_shadow", shadow, 5'b00101);
      check("plan_shr_lost", lost, 1);
      run_cmd(CMD_LOAD_SHL, 3, 5'b00011, 0);
      check("plan_lshl3_shadow", shadow, 5'b11000);
      check("plan_lshl3_lost", lost, 0);
      run_cmd(CMD_LOAD_SHL, 4, 5'b00011, 0);
      check("plan_lshl4_shadow", shadow, 5'b10000);
      check("plan_lshl4_lost", lost, 1);
      run_cmd(CMD_SHL, 0, 0, 0);
      check("plan_shl0_shadow", shadow, 5'b10000);
      run_cmd(CMD_SHR, 3, 0, 1);
      run_cmd(CMD_LOAD, 0, 5'b01101, 0);
      run_cmd(CMD_SHR, 7, 0, 0);
      run_cmd(CMD_LOAD_SHL, 0, 5'b11111, 1);

      // reset in the middle of a 5-cycle SHR
      @(negedge clk);
      start  = 1'b1;
      cmd    = CMD_SHR;
      amount = CNT_W'(5);
      din    = '0;
      tick();
      start = 1'b0;
      check("mid_rst_t1_op", op_reg, OPR_SHR);
      tick();
      check("mid_rst_t2_op", op_reg, OPR_SHR);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_shadow = 0;
      m_lost   = 0;
      check("mid_rst_op", op_reg, OPR_HOLD);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_shadow", shadow, 0);
      check("mid_rst_lost", lost, 0);
      check("mid_rst_reg_in", reg_in, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("mid_rst_no_done", done, 0);
         check("mid_rst_no_busy", busy, 0);
      end

      // rst and start together: rst wins
      @(negedge clk);
      rst    = 1'b1;
      start  = 1'b1;
      cmd    = CMD_LOAD;
      din    = 5'b01001;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", busy, 0);
      check("rst_start_reg_in", reg_in, 0);
      tick();
      check("rst_start_busy2", busy, 0);
      check("rst_start_op", op_reg, OPR_HOLD);
      check("rst_start_shadow", shadow, 0);

      // random commands
      for (int k = 0; k < 40; k++) begin
         run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7),
                 $urandom_range(0, 31), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) begin
            tick();
            check("gap_busy", busy, 0);
            check("gap_shadow", shadow, m_shadow);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
